fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_VECTOR, default 32'h0000_0000: PC_Next value driven while reset is asserted.
REQ-002 SHALL provide parameter LU_BUBBLES, default 1, range 1-3: stall cycles inserted per load-use hazard.
REQ-003 SHALL provide parameter MAX_WAIT, default 15, range 1-255: IMEM wait cycles tolerated before the timeout error.
REQ-004 SHALL have port CLOCK  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET  in  1  synchronous, active-low reset, sampled on the rising edge of CLOCK.
REQ-006 SHALL have port PC_Cur  in  32  current PC, taken from the PC register output.
REQ-007 SHALL have port BR_Taken  in  1  EX-stage branch or jump resolved taken.
REQ-008 SHALL have port BR_Target  in  32  redirect address, valid when BR_Taken=1.
REQ-009 SHALL have port LU_Hazard  in  1  decode reports a load-use dependency.
REQ-010 SHALL have port IMEM_Ready  in  1  instruction memory returned the fetch for PC_Cur.
REQ-011 SHALL have port PC_Next  out  32  next-PC value, feeds the PC register PC_In.
REQ-012 SHALL have port STALL  out  1  hold PC register and IF/ID latch.
REQ-013 SHALL have port FLUSH_IFID  out  1  squash the IF/ID entry.
REQ-014 SHALL have port FLUSH_IDEX  out  1  insert a bubble into ID/EX.
REQ-015 SHALL have port WAIT_ERR  out  1  sticky IMEM timeout flag.

Function
REQ-016 SHALL implement registered states RUN, BUBBLE, WAIT and REDIR; outputs SHALL be combinational from state and inputs.
REQ-017 RUN with no event SHALL drive PC_Next=PC_Cur+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) with STALL=0 and both flushes 0.
REQ-018 Event priority in any state SHALL be BR_Taken > LU_Hazard > !IMEM_Ready.
REQ-019 BR_Taken with IMEM_Ready=1 SHALL, in the same cycle, drive PC_Next=BR_Target, STALL=0, FLUSH_IFID=1 and FLUSH_IDEX=1; next state SHALL be RUN.
REQ-020 BR_Taken with IMEM_Ready=0 SHALL latch BR_Target into redir_q, assert FLUSH_IDEX and STALL, and enter REDIR.
REQ-021 REDIR SHALL hold STALL=1 while IMEM_Ready=0.
REQ-022 On the first cycle in REDIR with IMEM_Ready=1, the block SHALL drive PC_Next=redir_q, STALL=0 and FLUSH_IFID=1, then return to RUN.
REQ-023 A new BR_Taken during REDIR SHALL overwrite redir_q; the latest target wins.
REQ-024 LU_Hazard in RUN SHALL assert STALL=1 and FLUSH_IDEX=1, load bubble counter with LU_BUBBLES-1 and enter BUBBLE; with LU_BUBBLES=1 the block SHALL return directly to RUN.
REQ-025 BUBBLE SHALL keep STALL=1 and FLUSH_IDEX=1 and decrement the counter; it SHALL exit to RUN when the counter reaches 0.
REQ-026 LU_Hazard reasserted during BUBBLE SHALL NOT extend the bubble count.
REQ-027 BR_Taken during BUBBLE SHALL abort the bubble and follow REQ-019/REQ-020.
REQ-028 IMEM_Ready=0 in RUN SHALL assert STALL=1, clear the wait counter and enter WAIT; WAIT SHALL hold STALL=1 and increment the counter, saturating at 255.
REQ-029 WAIT SHALL exit to RUN on IMEM_Ready=1, driving normal RUN outputs in that cycle.
REQ-030 When the wait counter reaches MAX_WAIT, WAIT_ERR SHALL set and stay set until reset; STALL behaviour SHALL be unaffected.
REQ-031 While STALL=1, PC_Next SHALL equal PC_Cur, except in the REDIR release cycle.

Reset
REQ-032 While RESET=0 at a rising CLOCK edge, the block SHALL set state=RUN and clear redir_q, both counters and WAIT_ERR.
REQ-033 While RESET=0, outputs SHALL be PC_Next=RESET_VECTOR, STALL=0, FLUSH_IFID=1, FLUSH_IDEX=1 and WAIT_ERR=0, regardless of other inputs.
REQ-034 Reset asserted mid-REDIR or mid-BUBBLE SHALL discard the pending redirect or bubble; the first cycle after release SHALL be RUN behaviour.

Configuration
REQ-035 Macro FETCH_CTRL_STALL_CNT_EN, when defined, SHALL add output STALL_CNT (32 bits) counting cycles with STALL=1 and RESET=1, wrapping at 2^32 and reset to 0.
REQ-036 With FETCH_CTRL_STALL_CNT_EN undefined, the STALL_CNT port and its counter SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-037 The bench SHALL cover this scenario: reset release with PC_Cur=32'hFFFF_FFFC and IMEM_Ready=1 -> PC_Next=32'h0000_0000, STALL=0.
REQ-038 The bench SHALL cover this scenario: PC_Cur=32'h40 and BR_Taken=1 with BR_Target=32'h100 -> PC_Next=32'h100, FLUSH_IFID=1 and FLUSH_IDEX=1 in the same cycle.
REQ-039 The bench SHALL cover this scenario: LU_BUBBLES=2 and a one-cycle LU_Hazard pulse -> STALL=1 for exactly 2 cycles, then PC_Next=PC_Cur+4.
REQ-040 The bench SHALL cover this scenario: BR_Taken (BR_Target=32'h200) with IMEM_Ready=0 for 3 cycles -> STALL=1 for 3 cycles, then one cycle with PC_Next=32'h200 and FLUSH_IFID=1.
REQ-041 The bench SHALL cover this scenario: MAX_WAIT=4 with IMEM_Ready=0 for 6 cycles -> WAIT_ERR rises on the 4th wait cycle and remains 1 after IMEM_Ready returns.
REQ-042 The bench SHALL cover this scenario: RESET=0 asserted during REDIR -> after release, PC_Next=PC_Cur+4 and redir_q is not applied.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: next-PC selection and IF-stage hazard control.
// Resolves taken branches, load-use bubbles and instruction-memory wait
// states into PC_Next, STALL and the two pipeline-register flushes.
// A branch that resolves while IMEM is busy is parked in a redirect
// register and applied on the first ready cycle.
// Optional feature: define FETCH_CTRL_STALL_CNT_EN to add the 32-bit
// STALL_CNT output counting stalled cycles outside reset.
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          LU_BUBBLES   = 1,
    parameter int          MAX_WAIT     = 15
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] PC_Cur,
    input  logic        BR_Taken,
    input  logic [31:0] BR_Target,
    input  logic        LU_Hazard,
    input  logic        IMEM_Ready,
    output logic [31:0] PC_Next,
    output logic        STALL,
    output logic        FLUSH_IFID,
    output logic        FLUSH_IDEX,
`ifdef FETCH_CTRL_STALL_CNT_EN
    output logic [31:0] STALL_CNT,
`endif
    output logic        WAIT_ERR
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REDIR  = 2'd3
    } state_e;

    localparam logic [1:0] BUB_LOAD   = 2'(LU_BUBBLES - 1);
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_e      state_q, state_d;
    logic [31:0] redir_q, redir_d;
    logic [1:0]  bub_cnt_q, bub_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic        err_set;

    logic [31:0] pc_next;
    logic        stall, flush_ifid, flush_idex;

    // Next-state and raw outputs; a branch outranks every state-specific action.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d    = state_q;
        redir_d    = redir_q;
        bub_cnt_d  = bub_cnt_q;
        wait_cnt_d = wait_cnt_q;
        err_set    = 1'b0;
        pc_next    = PC_Cur + 32'd4;
        stall      = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;

        if (BR_Taken) begin
            flush_idex = 1'b1;
            if (IMEM_Ready) begin
                pc_next    = BR_Target;
                flush_ifid = 1'b1;
                state_d    = ST_RUN;
            end else begin
                // Park the target; a later branch simply overwrites it.
                pc_next = PC_Cur;
                stall   = 1'b1;
                redir_d = BR_Target;
                state_d = ST_REDIR;
            end
        end else begin
            case (state_q)
                ST_RUN, ST_WAIT: begin
                    if (LU_Hazard) begin
                        pc_next    = PC_Cur;
                        stall      = 1'b1;
                        flush_idex = 1'b1;
                        bub_cnt_d  = BUB_LOAD;
                        state_d    = (LU_BUBBLES == 1) ? ST_RUN : ST_BUBBLE;
                    end else if (!IMEM_Ready) begin
                        pc_next = PC_Cur;
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                        if (state_q == ST_RUN) begin
                            wait_cnt_d = 8'd0;
                        end else begin
                            if (wait_cnt_q != 8'hFF) begin
                                wait_cnt_d = wait_cnt_q + 8'd1;
                            end
                            err_set = (wait_cnt_d == MAX_WAIT_C);
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_BUBBLE: begin
                    // A hazard seen here is ignored: the count only runs down.
                    pc_next    = PC_Cur;
                    stall      = 1'b1;
                    flush_idex = 1'b1;
                    if (bub_cnt_q <= 2'd1) begin
                        bub_cnt_d = 2'd0;
                        state_d   = ST_RUN;
                    end else begin
                        bub_cnt_d = bub_cnt_q - 2'd1;
                    end
                end
                ST_REDIR: begin
                    if (IMEM_Ready) begin
                        pc_next    = redir_q;
                        flush_ifid = 1'b1;
                        state_d    = ST_RUN;
                    end else begin
                        // IF/ID still holds a wrong-path instruction: keep it out of EX.
                        pc_next    = PC_Cur;
                        stall      = 1'b1;
                        flush_idex = 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        err_d = err_q | err_set;
    end

    // Port drivers: reset forces a fixed, input-independent output pattern.
    always_comb begin
        if (!RESET) begin
            PC_Next    = RESET_VECTOR;
            STALL      = 1'b0;
            FLUSH_IFID = 1'b1;
            FLUSH_IDEX = 1'b1;
            WAIT_ERR   = 1'b0;
        end else begin
            PC_Next    = pc_next;
            STALL      = stall;
            FLUSH_IFID = flush_ifid;
            FLUSH_IDEX = flush_idex;
            WAIT_ERR   = err_q | err_set;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLOCK) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!RESET) begin
            state_q    <= ST_RUN;
            redir_q    <= 32'd0;
            bub_cnt_q  <= 2'd0;
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            redir_q    <= redir_d;
            bub_cnt_q  <= bub_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

`ifdef FETCH_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Free-running count of stalled cycles; wraps naturally at 2^32.
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
    end

    // Stall counter register.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`endif

endmodule
